// File: rtl/alu_ctrl_fsm_if.sv
// ----------------------------------------------------------------------------
// alu_ctrl_fsm_if
//
// Purpose: bundles every signal exchanged between the multi-cycle control
// sequencer (alu_ctrl_fsm) and the datapath/memory it steers.
//
// Signals:
//   opcode   [3:0]  IR[15:12], stable from DECODE until the next FETCH ends
//   zero            ALU zero flag
//   memready        memory completion for the current request
//   srca     [2:0]  ALU A select   0 PC, 1 ACC, 2 SP
//   srcb     [3:0]  ALU B select   0 const 2, 1 SE, 2 ZE, 3 SL1, 4 MemData,
//                                  5 const 0
//   aluop    [2:0]  0 ADD, 1 SUB, 2 AND, 3 OR, 4 PASSB
//   pcwrite, irwrite, accwrite, spwrite   one-cycle register write strobes
//   memread, memwrite                     memory requests
//   iord            address select  0 PC, 1 ALU out
//   halted          high while the sequencer sits in HALT
//   illegal         one-cycle pulse for an undefined opcode
//
// Handshake: memread/memwrite act as "valid". Once raised, a request and its
// address select stay unchanged until the cycle in which memready is high;
// that cycle is the transfer, and the request drops on the following edge
// unless a new request starts. memready is ignored while no request is up.
//
// Modports: master = sequencer, slave = datapath/memory side.
// ----------------------------------------------------------------------------
interface alu_ctrl_fsm_if;
    logic [3:0] opcode;
    logic       zero;
    logic       memready;
    logic [2:0] srca;
    logic [3:0] srcb;
    logic [2:0] aluop;
    logic       pcwrite;
    logic       irwrite;
    logic       accwrite;
    logic       spwrite;
    logic       memread;
    logic       memwrite;
    logic       iord;
    logic       halted;
    logic       illegal;

    modport master (
        input  opcode, zero, memready,
        output srca, srcb, aluop, pcwrite, irwrite, accwrite, spwrite,
               memread, memwrite, iord, halted, illegal
    );

    modport slave (
        output opcode, zero, memready,
        input  srca, srcb, aluop, pcwrite, irwrite, accwrite, spwrite,
               memread, memwrite, iord, halted, illegal
    );
endinterface

// File: rtl/alu_ctrl_fsm.sv
// ----------------------------------------------------------------------------
// alu_ctrl_fsm
//
// Purpose: multi-cycle control sequencer for a small accumulator machine.
// Walks FETCH -> DECODE -> {EXEC | MEM [-> WB] | BR | HALT} -> FETCH and
// drives ALU operand selects, ALU operation, register write strobes and
// memory requests.
//
// Ports:
//   clk        system clock, all state changes on the rising edge
//   rst_n      asynchronous active-low reset; forces FETCH, AccZ=0 and every
//              control output to 0 immediately
//   bus        alu_ctrl_fsm_if.master (opcode/zero/memready in, controls out)
//   state_dbg  current sequencer state encoding (see state_t)
//
// Configuration macro: STACK_OPS_EN
//   defined   -> opcode 9 PUSH and opcode A POP are executed using SP
//   undefined -> opcodes 9 and A are undefined and spwrite is tied to 0
//
// Timing: the first rising edge after reset release loads the FETCH controls.
// With memready tied high: ALU-immediate, branch and SW take 3 cycles, LW 4;
// every cycle without memready in FETCH or MEM adds one.
// ----------------------------------------------------------------------------
module alu_ctrl_fsm (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_ctrl_fsm_if.master        bus,
    output logic [2:0]            state_dbg
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_BR     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    // Operand / operation encodings
    localparam logic [2:0] A_PC      = 3'd0;
    localparam logic [2:0] A_ACC     = 3'd1;
    localparam logic [2:0] A_SP      = 3'd2;

    localparam logic [3:0] B_TWO     = 4'd0;
    localparam logic [3:0] B_SE      = 4'd1;
    localparam logic [3:0] B_ZE      = 4'd2;
    localparam logic [3:0] B_SL1     = 4'd3;
    localparam logic [3:0] B_MEM     = 4'd4;
    localparam logic [3:0] B_ZERO    = 4'd5;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_AND   = 3'd2;
    localparam logic [2:0] ALU_OR    = 3'd3;
    localparam logic [2:0] ALU_PASSB = 3'd4;

    localparam logic [3:0] OP_LDI    = 4'h0;
    localparam logic [3:0] OP_ADDI   = 4'h1;
    localparam logic [3:0] OP_SUBI   = 4'h2;
    localparam logic [3:0] OP_ANDI   = 4'h3;
    localparam logic [3:0] OP_ORI    = 4'h4;
    localparam logic [3:0] OP_LW     = 4'h5;
    localparam logic [3:0] OP_SW     = 4'h6;
    localparam logic [3:0] OP_BEQZ   = 4'h7;
    localparam logic [3:0] OP_J      = 4'h8;
`ifdef STACK_OPS_EN
    localparam logic [3:0] OP_PUSH   = 4'h9;
    localparam logic [3:0] OP_POP    = 4'hA;
`endif
    localparam logic [3:0] OP_HALT   = 4'hF;

    state_t     state;
    logic       accz;
    logic [2:0] srca_q;
    logic [3:0] srcb_q;
    logic [2:0] aluop_q;
    logic       accwrite_q;
    logic       memread_q;
    logic       memwrite_q;
    logic       iord_q;
    logic       halted_q;
`ifdef STACK_OPS_EN
    logic       spwrite_q;
`endif

    logic       opcode_defined;
    logic       fetch_done;
    logic       br_taken;

    always_comb begin
        opcode_defined = 1'b0;
        case (bus.opcode)
            OP_LDI, OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI,
            OP_LW, OP_SW, OP_BEQZ, OP_J, OP_HALT: opcode_defined = 1'b1;
`ifdef STACK_OPS_EN
            OP_PUSH, OP_POP:                      opcode_defined = 1'b1;
`endif
            default:                              opcode_defined = 1'b0;
        endcase
    end

    // FETCH completes in whichever cycle memready arrives, so the IR/PC
    // strobes cannot be registered ahead of time; they are the registered
    // request qualified by memready. memread_q is 0 in the reset-idle FETCH,
    // which keeps these strobes low while reset is (or was just) active.
    assign fetch_done = (state == S_FETCH) && memread_q && bus.memready;

    // BR uses the AccZ flag captured in DECODE; J branches unconditionally.
    // The opcode is still held in IR during BR.
    assign br_taken   = (state == S_BR) && ((bus.opcode != OP_BEQZ) || accz);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_FETCH;
            accz       <= 1'b0;
            srca_q     <= A_PC;
            srcb_q     <= B_TWO;
            aluop_q    <= ALU_ADD;
            accwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            iord_q     <= 1'b0;
            halted_q   <= 1'b0;
`ifdef STACK_OPS_EN
            spwrite_q  <= 1'b0;
`endif
        end else begin
            // Defaults are the FETCH datapath setting (PC + 2) with every
            // strobe low; each branch below only states what differs.
            srca_q     <= A_PC;
            srcb_q     <= B_TWO;
            aluop_q    <= ALU_ADD;
            accwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            iord_q     <= 1'b0;
`ifdef STACK_OPS_EN
            spwrite_q  <= 1'b0;
`endif
            case (state)
                S_FETCH: begin
                    if (memread_q && bus.memready) begin
                        // DECODE evaluates ACC - 0 so Zero reflects ACC
                        state   <= S_DECODE;
                        srca_q  <= A_ACC;
                        srcb_q  <= B_ZERO;
                        aluop_q <= ALU_SUB;
                    end else begin
                        memread_q <= 1'b1;
                    end
                end

                S_DECODE: begin
                    accz <= bus.zero;
                    case (bus.opcode)
                        OP_LDI, OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI: begin
                            state      <= S_EXEC;
                            srca_q     <= A_ACC;
                            accwrite_q <= 1'b1;
                            case (bus.opcode)
                                OP_ADDI: begin srcb_q <= B_SE; aluop_q <= ALU_ADD;   end
                                OP_SUBI: begin srcb_q <= B_SE; aluop_q <= ALU_SUB;   end
                                OP_ANDI: begin srcb_q <= B_ZE; aluop_q <= ALU_AND;   end
                                OP_ORI:  begin srcb_q <= B_ZE; aluop_q <= ALU_OR;    end
                                default: begin srcb_q <= B_ZE; aluop_q <= ALU_PASSB; end
                            endcase
                        end
                        OP_LW: begin
                            state     <= S_MEM;
                            srcb_q    <= B_ZE;
                            aluop_q   <= ALU_PASSB;
                            iord_q    <= 1'b1;
                            memread_q <= 1'b1;
                        end
                        OP_SW: begin
                            state      <= S_MEM;
                            srcb_q     <= B_ZE;
                            aluop_q    <= ALU_PASSB;
                            iord_q     <= 1'b1;
                            memwrite_q <= 1'b1;
                        end
                        OP_BEQZ: begin
                            state   <= S_BR;
                            srca_q  <= A_PC;
                            srcb_q  <= B_SL1;
                            aluop_q <= ALU_ADD;
                        end
                        OP_J: begin
                            state   <= S_BR;
                            srcb_q  <= B_ZE;
                            aluop_q <= ALU_PASSB;
                        end
                        OP_HALT: begin
                            state    <= S_HALT;
                            halted_q <= 1'b1;
                        end
`ifdef STACK_OPS_EN
                        OP_PUSH: begin
                            // pre-decrement SP, then store ACC at new SP
                            state     <= S_EXEC;
                            srca_q    <= A_SP;
                            srcb_q    <= B_TWO;
                            aluop_q   <= ALU_SUB;
                            spwrite_q <= 1'b1;
                        end
                        OP_POP: begin
                            state     <= S_MEM;
                            srca_q    <= A_SP;
                            srcb_q    <= B_ZERO;
                            aluop_q   <= ALU_ADD;
                            iord_q    <= 1'b1;
                            memread_q <= 1'b1;
                        end
`endif
                        default: begin
                            // undefined: illegal pulses combinationally in
                            // this cycle, nothing is written
                            state     <= S_FETCH;
                            memread_q <= 1'b1;
                        end
                    endcase
                end

                S_EXEC: begin
`ifdef STACK_OPS_EN
                    if (bus.opcode == OP_PUSH) begin
                        state      <= S_MEM;
                        srca_q     <= A_SP;
                        srcb_q     <= B_ZERO;
                        aluop_q    <= ALU_ADD;
                        iord_q     <= 1'b1;
                        memwrite_q <= 1'b1;
                    end else begin
                        state     <= S_FETCH;
                        memread_q <= 1'b1;
                    end
`else
                    state     <= S_FETCH;
                    memread_q <= 1'b1;
`endif
                end

                S_MEM: begin
                    if (!bus.memready) begin
                        // hold the whole request steady while waiting
                        srca_q     <= srca_q;
                        srcb_q     <= srcb_q;
                        aluop_q    <= aluop_q;
                        iord_q     <= iord_q;
                        memread_q  <= memread_q;
                        memwrite_q <= memwrite_q;
                    end else if (bus.opcode == OP_LW) begin
                        state      <= S_WB;
                        srcb_q     <= B_MEM;
                        aluop_q    <= ALU_PASSB;
                        accwrite_q <= 1'b1;
                    end
`ifdef STACK_OPS_EN
                    else if (bus.opcode == OP_POP) begin
                        // ALU computes SP + 2; ACC loads the memory data
                        // register through its own load path
                        state      <= S_WB;
                        srca_q     <= A_SP;
                        srcb_q     <= B_TWO;
                        aluop_q    <= ALU_ADD;
                        accwrite_q <= 1'b1;
                        spwrite_q  <= 1'b1;
                    end
`endif
                    else begin
                        state     <= S_FETCH;
                        memread_q <= 1'b1;
                    end
                end

                S_WB, S_BR: begin
                    state     <= S_FETCH;
                    memread_q <= 1'b1;
                end

                S_HALT: begin
                    // absorbing; only rst_n leaves HALT
                    state <= S_HALT;
                end

                default: begin
                    state     <= S_FETCH;
                    memread_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.srca     = srca_q;
    assign bus.srcb     = srcb_q;
    assign bus.aluop    = aluop_q;
    assign bus.pcwrite  = fetch_done || br_taken;
    assign bus.irwrite  = fetch_done;
    assign bus.accwrite = accwrite_q;
    assign bus.memread  = memread_q;
    assign bus.memwrite = memwrite_q;
    assign bus.iord     = iord_q;
    assign bus.halted   = halted_q;
    assign bus.illegal  = (state == S_DECODE) && !opcode_defined;
`ifdef STACK_OPS_EN
    assign bus.spwrite  = spwrite_q;
`else
    assign bus.spwrite  = 1'b0;
`endif

    assign state_dbg    = state;

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// ----------------------------------------------------------------------------
// tb_alu_ctrl_fsm
//
// Directed test of alu_ctrl_fsm. Each task starts in a FETCH cycle and leaves
// the sequencer at the start of the next FETCH cycle. Observed vector layout:
//   {state[2:0], srca[2:0], srcb[3:0], aluop[2:0],
//    pcwrite, irwrite, accwrite, spwrite, memread, memwrite, iord,
//    halted, illegal}
// ----------------------------------------------------------------------------
module tb_alu_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] state_dbg;

    alu_ctrl_fsm_if bus ();

    alu_ctrl_fsm dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [21:0] obs;
    assign obs = {state_dbg, bus.srca, bus.srcb, bus.aluop,
                  bus.pcwrite, bus.irwrite, bus.accwrite, bus.spwrite,
                  bus.memread, bus.memwrite, bus.iord, bus.halted, bus.illegal};

    // FETCH with memready high / low, and the DECODE cycle
    localparam logic [21:0] F_RDY  = {3'd0, 3'd0, 4'd0, 3'd0, 9'b110010000};
    localparam logic [21:0] F_WAIT = {3'd0, 3'd0, 4'd0, 3'd0, 9'b000010000};
    localparam logic [21:0] DEC    = {3'd1, 3'd1, 4'd5, 3'd1, 9'b000000000};
    localparam logic [21:0] DEC_IL = {3'd1, 3'd1, 4'd5, 3'd1, 9'b000000001};

    function automatic logic [21:0] v(input logic [2:0] st, input logic [2:0] a,
                                      input logic [3:0] b, input logic [2:0] op,
                                      input logic [8:0] f);
        return {st, a, b, op, f};
    endfunction

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset;
        rst_n        = 1'b0;
        bus.opcode   = 4'h0;
        bus.zero     = 1'b0;
        bus.memready = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        n_checks++;
        if (obs !== 22'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected %h", obs, 22'd0);
        end
        rst_n = 1'b1;
        tick;
    endtask

    // Opcodes 0..4, back to back, memready tied high
    task automatic test_alu_imm;
        logic [21:0] e_exec [5];
        logic [21:0] e [3];
        e_exec = '{v(3'd2, 3'd1, 4'd2, 3'd4, 9'b001000000),
                   v(3'd2, 3'd1, 4'd1, 3'd0, 9'b001000000),
                   v(3'd2, 3'd1, 4'd1, 3'd1, 9'b001000000),
                   v(3'd2, 3'd1, 4'd2, 3'd2, 9'b001000000),
                   v(3'd2, 3'd1, 4'd2, 3'd3, 9'b001000000)};
        for (int k = 0; k < 5; k++) begin
            bus.opcode = k[3:0];
            e = '{F_RDY, DEC, e_exec[k]};
            for (int i = 0; i < 3; i++) begin
                bus.memready = 1'b1;
                #1;
                n_checks++;
                if (obs !== e[i]) begin
                    n_fail++;
                    $display("FAIL alu_imm op%0d cyc%0d: got %h expected %h", k, i, obs, e[i]);
                end
                tick;
            end
        end
    endtask

    // LW with two wait cycles in MEM
    task automatic test_lw_wait;
        logic [21:0] e [6];
        logic        r [6];
        bus.opcode = 4'h5;
        e = '{F_RDY, DEC,
              v(3'd3, 3'd0, 4'd2, 3'd4, 9'b000010100),
              v(3'd3, 3'd0, 4'd2, 3'd4, 9'b000010100),
              v(3'd3, 3'd0, 4'd2, 3'd4, 9'b000010100),
              v(3'd4, 3'd0, 4'd4, 3'd4, 9'b001000000)};
        r = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 6; i++) begin
            bus.memready = r[i];
            #1;
            n_checks++;
            if (obs !== e[i]) begin
                n_fail++;
                $display("FAIL lw_wait cyc%0d: got %h expected %h", i, obs, e[i]);
            end
            tick;
        end
    endtask

    // SW with one wait cycle in FETCH, memory accepts at once
    task automatic test_sw_fetch_wait;
        logic [21:0] e [4];
        logic        r [4];
        bus.opcode = 4'h6;
        e = '{F_WAIT, F_RDY, DEC, v(3'd3, 3'd0, 4'd2, 3'd4, 9'b000001100)};
        r = '{1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            bus.memready = r[i];
            #1;
            n_checks++;
            if (obs !== e[i]) begin
                n_fail++;
                $display("FAIL sw_fetch_wait cyc%0d: got %h expected %h", i, obs, e[i]);
            end
            tick;
        end
    endtask

    // BEQZ taken / not taken, then J
    task automatic test_branch;
        logic [21:0] e_br [3];
        logic [3:0]  ops  [3];
        logic        zs   [3];
        logic [21:0] e [3];
        e_br = '{v(3'd5, 3'd0, 4'd3, 3'd0, 9'b100000000),
                 v(3'd5, 3'd0, 4'd3, 3'd0, 9'b000000000),
                 v(3'd5, 3'd0, 4'd2, 3'd4, 9'b100000000)};
        ops  = '{4'h7, 4'h7, 4'h8};
        zs   = '{1'b1, 1'b0, 1'b0};
        for (int k = 0; k < 3; k++) begin
            bus.opcode = ops[k];
            bus.zero   = zs[k];
            e = '{F_RDY, DEC, e_br[k]};
            for (int i = 0; i < 3; i++) begin
                bus.memready = 1'b1;
                #1;
                n_checks++;
                if (obs !== e[i]) begin
                    n_fail++;
                    $display("FAIL branch case%0d cyc%0d: got %h expected %h", k, i, obs, e[i]);
                end
                tick;
            end
        end
        bus.zero = 1'b0;
    endtask

    // Always-undefined opcodes, plus 9/A when stack ops are compiled out
    task automatic test_illegal;
`ifdef STACK_OPS_EN
        logic [3:0] ops [4];
        ops = '{4'hB, 4'hC, 4'hD, 4'hE};
        for (int k = 0; k < 4; k++) begin
`else
        logic [3:0] ops [6];
        ops = '{4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE};
        for (int k = 0; k < 6; k++) begin
`endif
            bus.opcode   = ops[k];
            bus.memready = 1'b1;
            #1;
            n_checks++;
            if (obs !== F_RDY) begin
                n_fail++;
                $display("FAIL illegal_fetch op%h: got %h expected %h", ops[k], obs, F_RDY);
            end
            tick;
            n_checks++;
            if (obs !== DEC_IL) begin
                n_fail++;
                $display("FAIL illegal_decode op%h: got %h expected %h", ops[k], obs, DEC_IL);
            end
            tick;
        end
    endtask

`ifdef STACK_OPS_EN
    // PUSH: EXEC SP-2 with SPWrite, MEM write at SP; POP: MEM read, WB
    task automatic test_stack;
        logic [21:0] e [7];
        logic [3:0]  op [7];
        e  = '{F_RDY, DEC,
               v(3'd2, 3'd2, 4'd0, 3'd1, 9'b000100000),
               v(3'd3, 3'd2, 4'd5, 3'd0, 9'b000001100),
               F_RDY, DEC,
               v(3'd3, 3'd2, 4'd5, 3'd0, 9'b000010100)};
        op = '{4'h9, 4'h9, 4'h9, 4'h9, 4'hA, 4'hA, 4'hA};
        for (int i = 0; i < 7; i++) begin
            bus.opcode   = op[i];
            bus.memready = 1'b1;
            #1;
            n_checks++;
            if (obs !== e[i]) begin
                n_fail++;
                $display("FAIL stack cyc%0d: got %h expected %h", i, obs, e[i]);
            end
            tick;
        end
        n_checks++;
        if (obs !== v(3'd4, 3'd2, 4'd0, 3'd0, 9'b001100000)) begin
            n_fail++;
            $display("FAIL stack_pop_wb: got %h expected %h", obs,
                     v(3'd4, 3'd2, 4'd0, 3'd0, 9'b001100000));
        end
        tick;
    endtask
`endif

    // Reset asserted while SW waits in MEM
    task automatic test_reset_mid_wait;
        logic [21:0] e [4];
        logic        r [4];
        bus.opcode = 4'h6;
        e = '{F_RDY, DEC,
              v(3'd3, 3'd0, 4'd2, 3'd4, 9'b000001100),
              v(3'd3, 3'd0, 4'd2, 3'd4, 9'b000001100)};
        r = '{1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            bus.memready = r[i];
            #1;
            n_checks++;
            if (obs !== e[i]) begin
                n_fail++;
                $display("FAIL midwait cyc%0d: got %h expected %h", i, obs, e[i]);
            end
            if (i < 3) tick;
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs !== 22'd0) begin
            n_fail++;
            $display("FAIL midwait_async_reset: got %h expected %h", obs, 22'd0);
        end
        bus.memready = 1'b1;
        tick;
        rst_n = 1'b1;
        tick;
        n_checks++;
        if (obs !== F_RDY) begin
            n_fail++;
            $display("FAIL midwait_restart: got %h expected %h", obs, F_RDY);
        end
    endtask

    // HALT is absorbing; only reset leaves it
    task automatic test_halt;
        logic [21:0] e_halt;
        e_halt = v(3'd6, 3'd0, 4'd0, 3'd0, 9'b000000010);
        bus.opcode   = 4'hF;
        bus.memready = 1'b1;
        #1;
        n_checks++;
        if (obs !== F_RDY) begin
            n_fail++;
            $display("FAIL halt_fetch: got %h expected %h", obs, F_RDY);
        end
        tick;
        n_checks++;
        if (obs !== DEC) begin
            n_fail++;
            $display("FAIL halt_decode: got %h expected %h", obs, DEC);
        end
        tick;
        for (int i = 0; i < 5; i++) begin
            bus.memready = i[0];
            bus.opcode   = (i == 2) ? 4'h1 : 4'hF;
            #1;
            n_checks++;
            if (obs !== e_halt) begin
                n_fail++;
                $display("FAIL halt_hold cyc%0d: got %h expected %h", i, obs, e_halt);
            end
            tick;
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs !== 22'd0) begin
            n_fail++;
            $display("FAIL halt_reset: got %h expected %h", obs, 22'd0);
        end
        bus.memready = 1'b1;
        bus.opcode   = 4'h1;
        tick;
        rst_n = 1'b1;
        tick;
        n_checks++;
        if (obs !== F_RDY) begin
            n_fail++;
            $display("FAIL halt_restart: got %h expected %h", obs, F_RDY);
        end
    endtask

    initial begin
        test_reset();
        test_alu_imm();
        test_lw_wait();
        test_sw_fetch_wait();
        test_branch();
        test_illegal();
`ifdef STACK_OPS_EN
        test_stack();
`endif
        test_reset_mid_wait();
        test_halt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_fsm.md
ALU_CTRL_FSM -- requirements
Module: alu_ctrl_fsm

Interface
REQ-001 CLK  input  1  single system clock; all state changes on rising edge.
REQ-002 RST_N  input  1  asynchronous, active-low reset.
REQ-003 Opcode  input  4  IR[15:12], valid from DECODE onward.
REQ-004 Zero  input  1  Zero flag from the ALU subsystem.
REQ-005 MemReady  input  1  memory handshake: read data / write accepted this cycle.
REQ-006 SrcA  output  3  ALU A select: 0 PC, 1 ACC, 2 SP.
REQ-007 SrcB  output  4  ALU B select: 0 const 2, 1 SE, 2 ZE, 3 SL1, 4 MemData, 5 const 0.
REQ-008 ALUOP  output  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 PASSB.
REQ-009 PCWrite, IRWrite, ACCWrite, SPWrite  output  1 each  register write strobes.
REQ-010 MemRead, MemWrite  output  1 each  memory request; held until MemReady.
REQ-011 IorD  output  1  address select: 0 PC, 1 ALU out.
REQ-012 Halted, Illegal  output  1 each  halt status; one-cycle pulse on undefined opcode.

Function
REQ-013 States SHALL be FETCH, DECODE, EXEC, MEM, WB, BR, HALT.
REQ-014 FETCH SHALL assert MemRead with IorD=0 until MemReady; on the MemReady cycle it SHALL assert IRWrite and PCWrite with SrcA=0, SrcB=0, ALUOP=ADD (PC+2), then go to DECODE.
REQ-015 DECODE SHALL last one cycle, drive SrcA=1, SrcB=5, ALUOP=SUB, and latch Zero into an internal flag AccZ.
REQ-016 Opcodes 0-4 (LDI PASSB ZE, ADDI ADD SE, SUBI SUB SE, ANDI AND ZE, ORI OR ZE) SHALL go DECODE->EXEC; EXEC asserts ACCWrite with SrcA=1 and returns to FETCH.
REQ-017 Opcode 5 (LW) SHALL go MEM (SrcB=2, PASSB, IorD=1, MemRead until MemReady) then WB (SrcB=4, PASSB, ACCWrite) then FETCH.
REQ-018 Opcode 6 (SW) SHALL go MEM with MemWrite, IorD=1, address ZE, held until MemReady, then FETCH.
REQ-019 Opcode 7 (BEQZ) SHALL go BR: SrcA=0, SrcB=3, ADD; PCWrite asserted iff AccZ=1; then FETCH.
REQ-020 Opcode 8 (J) SHALL go BR with SrcB=2, PASSB, PCWrite unconditional.
REQ-021 Opcode F SHALL enter HALT; HALT asserts Halted=1, no strobes, and exits only on reset.
REQ-022 Undefined opcodes SHALL pulse Illegal for one cycle in DECODE and return to FETCH with no writes.
REQ-023 Every write strobe SHALL be high for exactly one cycle per instruction; memory strobes remain high only while waiting for MemReady.
REQ-024 With MemReady tied high: ALU-imm/BR 3 cycles, SW 3, LW 4; each wait cycle adds one.

Reset
REQ-025 RST_N low SHALL immediately force state FETCH, AccZ=0, and all outputs 0, including mid-wait or in HALT.
REQ-026 The first rising edge after RST_N release SHALL evaluate FETCH; no strobe is asserted during reset.

Configuration
REQ-027 With STACK_OPS_EN defined, opcode 9 (PUSH: EXEC SP=SP-2 via SrcA=2, SrcB=0, SUB, SPWrite; then MEM write ACC at SP) and opcode A (POP: MEM read at SP; WB ACCWrite and SP=SP+2) SHALL be implemented.
REQ-028 Without STACK_OPS_EN, opcodes 9 and A SHALL be treated as undefined per REQ-022, and SPWrite SHALL be constant 0.

Verification
REQ-029 Reset, MemReady=1, Opcode=1 -> FETCH(IRWrite,PCWrite), DECODE, EXEC(ACCWrite, SrcB=1, ALUOP=0); next FETCH at cycle 4.
REQ-030 Opcode=5, MemReady low for 2 cycles in MEM -> MemRead held 3 cycles, IorD=1, then one WB cycle with ACCWrite, SrcB=4.
REQ-031 Opcode=7 with Zero=1 in DECODE -> BR PCWrite=1, SrcB=3; repeat with Zero=0 -> PCWrite=0.
REQ-032 Opcode=F -> Halted=1 indefinitely with no strobes; RST_N pulse -> Halted=0, state FETCH.
REQ-033 RST_N asserted during MEM wait with MemWrite=1 -> MemWrite drops asynchronously, restart in FETCH.
REQ-034 Opcode=9 without STACK_OPS_EN -> Illegal one-cycle pulse, no SPWrite; with the macro -> SPWrite then MemWrite at SP.
